// File: rtl/subterranean_lwc_fifo_in.sv
// Input-side circular FIFO for the Subterranean LWC core.
// Gated write/read sides, synchronous flush, async active-low reset.
module subterranean_lwc_fifo_in #(
  parameter int G_WIDTH = 32,
  parameter int G_DEPTH = 4,
  localparam int AW = $clog2(G_DEPTH),
  localparam int CW = AW + 1
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic [G_WIDTH-1:0] din,
  input  logic               din_valid,
  output logic               din_ready,
  output logic [G_WIDTH-1:0] dout,
  output logic               dout_valid,
  input  logic               dout_ready,
  input  logic               buffer_in_enable,
  input  logic               buffer_out_enable,
  input  logic               buffer_rst,
  output logic [CW-1:0]      level
);

  logic [G_WIDTH-1:0] mem [G_DEPTH];
  logic [AW-1:0]      wp;
  logic [AW-1:0]      rp;
  logic [CW-1:0]      cnt;
  logic               wr;
  logic               rd;
  logic               not_full;

  assign not_full   = cnt < CW'(G_DEPTH);
  assign dout_valid = buffer_out_enable & (cnt != '0);
  assign rd         = dout_valid & dout_ready;
  // A full FIFO may still accept when the head leaves this cycle.
  assign din_ready  = buffer_in_enable & (not_full | rd);
  assign wr         = din_valid & din_ready;
  assign dout       = buffer_out_enable ? mem[rp] : '0;
  assign level      = cnt;

  always_ff @(posedge clk) begin
    if (wr && !buffer_rst)
      mem[wp] <= din;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else if (buffer_rst) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else begin
      if (wr)
        wp <= wp + AW'(1);
      if (rd)
        rp <= rp + AW'(1);
      if (wr && !rd)
        cnt <= cnt + CW'(1);
      else if (rd && !wr)
        cnt <= cnt - CW'(1);
    end
  end

endmodule
